// File: rtl/fetch_ctrl_if.sv
// Fetch-control bus. It carries the hazard and branch inputs to the fetch
// controller, and the PC and pipeline-register controls that come back out.
interface fetch_ctrl_if #(
  parameter int CNT_WIDTH = 32
);
  logic [31:0]          pc_current;
  logic                 branch_taken;
  logic [31:0]          branch_target;
  logic                 load_use_hazard;
  logic                 mul_div_busy;
  logic                 imem_ready;
  logic                 pc_write_enable;
  logic [31:0]          pc_next;
  logic                 if_id_write_enable;
  logic                 if_id_flush;
  logic                 id_ex_flush;
  logic                 fetch_valid;
  logic [2:0]           state_out;
  logic                 imem_timeout;
  logic [CNT_WIDTH-1:0] stall_count;
  logic [CNT_WIDTH-1:0] flush_count;

  // Controller side
  modport master (
    input  pc_current, branch_taken, branch_target, load_use_hazard,
           mul_div_busy, imem_ready,
    output pc_write_enable, pc_next, if_id_write_enable, if_id_flush,
           id_ex_flush, fetch_valid, state_out, imem_timeout,
           stall_count, flush_count
  );

  // Pipeline / hazard-logic side
  modport slave (
    output pc_current, branch_taken, branch_target, load_use_hazard,
           mul_div_busy, imem_ready,
    input  pc_write_enable, pc_next, if_id_write_enable, if_id_flush,
           id_ex_flush, fetch_valid, state_out, imem_timeout,
           stall_count, flush_count
  );
endinterface

// File: rtl/fetch_control_unit.sv
// Fetch-stage sequencer for an RV32IM pipeline. Every cycle it chooses
// whether the PC advances, holds or redirects, and it drives the IF/ID and
// ID/EX enables and flushes. Outputs are Mealy and depend on the state and
// the inputs. Stall and flush activity is counted in saturating counters.
module fetch_control_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          BOOT_CYCLES  = 2,
  parameter int          MAX_WAIT     = 16,
  parameter int          CNT_WIDTH    = 32
) (
  input  logic          CLK,
  input  logic          RESET,
  fetch_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    ST_BOOT      = 3'd0,
    ST_RUN       = 3'd1,
    ST_STALL     = 3'd2,
    ST_IMEM_WAIT = 3'd3,
    ST_REDIRECT  = 3'd4
  } state_t;

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);
  localparam logic [7:0] WAIT_MAX  = 8'(MAX_WAIT);

  state_t               state_reg, state_next;
  logic [3:0]           boot_cnt_reg, boot_cnt_next;
  logic [7:0]           wait_cnt_reg, wait_cnt_next;
  logic                 timeout_reg, timeout_next;
  logic [CNT_WIDTH-1:0] stall_cnt_reg, stall_cnt_next;
  logic [CNT_WIDTH-1:0] flush_cnt_reg, flush_cnt_next;

  logic        pc_we, if_id_we, if_id_fl, id_ex_fl, fv;
  logic [31:0] pc_nxt, pc_plus4;
  logic        run_eval, hazard_eval;

  assign pc_plus4 = bus.pc_current + 32'd4;

  // State, boot/wait counters, sticky timeout and performance counters
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg     <= ST_BOOT;
      boot_cnt_reg  <= '0;
      wait_cnt_reg  <= '0;
      timeout_reg   <= 1'b0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      boot_cnt_reg  <= boot_cnt_next;
      wait_cnt_reg  <= wait_cnt_next;
      timeout_reg   <= timeout_next;
      stall_cnt_reg <= stall_cnt_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  // Next-state and output decode. RUN, an idle STALL and IMEM_WAIT share the
  // common priority chain. Only RUN also samples busy and load-use.
  always_comb begin
    state_next    = state_reg;
    boot_cnt_next = boot_cnt_reg;
    wait_cnt_next = '0;
    timeout_next  = timeout_reg;
    pc_we         = 1'b0;
    pc_nxt        = pc_plus4;
    if_id_we      = 1'b0;
    if_id_fl      = 1'b0;
    id_ex_fl      = 1'b0;
    fv            = 1'b0;
    run_eval      = 1'b0;
    hazard_eval   = 1'b0;

    case (state_reg)
      ST_BOOT: begin
        pc_nxt   = RESET_VECTOR;
        if_id_fl = 1'b1;
        id_ex_fl = 1'b1;
        if (boot_cnt_reg == BOOT_LAST) begin
          pc_we      = 1'b1;
          state_next = ST_RUN;
        end else begin
          boot_cnt_next = boot_cnt_reg + 4'd1;
        end
      end
      ST_RUN: begin
        run_eval    = 1'b1;
        hazard_eval = 1'b1;
      end
      ST_STALL: begin
        // A busy MUL/DIV holds everything, including any branch in EX.
        if (!bus.mul_div_busy) run_eval = 1'b1;
      end
      ST_IMEM_WAIT: run_eval = 1'b1;
      ST_REDIRECT: begin
        // Drop the stale word that the synchronous IMEM fetched behind the branch.
        pc_we      = 1'b1;
        if_id_fl   = 1'b1;
        state_next = ST_RUN;
      end
      default: state_next = ST_BOOT;
    endcase

    if (run_eval) begin
      if (bus.branch_taken) begin
        pc_we      = 1'b1;
        pc_nxt     = bus.branch_target;
        if_id_fl   = 1'b1;
        id_ex_fl   = 1'b1;
        state_next = ST_REDIRECT;
      end else if (hazard_eval && bus.mul_div_busy) begin
        state_next = ST_STALL;
      end else if (hazard_eval && bus.load_use_hazard) begin
        id_ex_fl   = 1'b1;
        state_next = ST_STALL;
      end else if (!bus.imem_ready) begin
        // The first not-ready cycle counts as wait cycle 1.
        if_id_fl   = 1'b1;
        state_next = ST_IMEM_WAIT;
        if (state_reg != ST_IMEM_WAIT)
          wait_cnt_next = 8'd1;
        else if (wait_cnt_reg != WAIT_MAX)
          wait_cnt_next = wait_cnt_reg + 8'd1;
        else
          wait_cnt_next = wait_cnt_reg;
        if (wait_cnt_next == WAIT_MAX) timeout_next = 1'b1;
      end else begin
        pc_we      = 1'b1;
        if_id_we   = 1'b1;
        fv         = 1'b1;
        state_next = ST_RUN;
      end
    end

    stall_cnt_next = stall_cnt_reg;
    flush_cnt_next = flush_cnt_reg;
    if (state_reg != ST_BOOT) begin
      if (!pc_we && (stall_cnt_reg != '1))
        stall_cnt_next = stall_cnt_reg + CNT_WIDTH'(1);
      if (if_id_fl && (flush_cnt_reg != '1))
        flush_cnt_next = flush_cnt_reg + CNT_WIDTH'(1);
    end
  end

  assign bus.pc_write_enable    = pc_we;
  assign bus.pc_next            = pc_nxt;
  assign bus.if_id_write_enable = if_id_we;
  assign bus.if_id_flush        = if_id_fl;
  assign bus.id_ex_flush        = id_ex_fl;
  assign bus.fetch_valid        = fv;
  assign bus.state_out          = state_reg;
  assign bus.imem_timeout       = timeout_reg;
  assign bus.stall_count        = stall_cnt_reg;
  assign bus.flush_count        = flush_cnt_reg;

endmodule

// File: tb/tb_fetch_control_unit.sv
// Directed bench for fetch_control_unit. A small PC register that follows
// pc_write_enable/pc_next drives pc_current. An override can force specific
// PC values.
module tb_fetch_control_unit;

  logic        CLK;
  logic        RESET;
  logic [31:0] pc_q;
  logic        pc_ovr_en;
  logic [31:0] pc_ovr;
  int          n_vec;
  int          n_bad;

  fetch_ctrl_if #(.CNT_WIDTH(32)) bus ();

  fetch_control_unit #(
    .RESET_VECTOR(32'h0000_0000),
    .BOOT_CYCLES (2),
    .MAX_WAIT    (16),
    .CNT_WIDTH   (32)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // PC register model
  always @(posedge CLK or negedge RESET) begin
    if (!RESET) pc_q <= 32'h0;
    else if (bus.pc_write_enable) pc_q <= bus.pc_next;
  end

  assign bus.pc_current = pc_ovr_en ? pc_ovr : pc_q;

  task automatic next_cycle();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    repeat (2) next_cycle();
    #1;
    n_vec++; if (bus.state_out !== 3'd0) begin n_bad++; $display("FAIL rst_state: got %0d want 0", bus.state_out); end
    n_vec++; if (bus.pc_write_enable !== 1'b0) begin n_bad++; $display("FAIL rst_pcwe: got %b want 0", bus.pc_write_enable); end
    n_vec++; if ({bus.if_id_flush, bus.id_ex_flush, bus.fetch_valid} !== 3'b110) begin n_bad++; $display("FAIL rst_flush: got %b want 110", {bus.if_id_flush, bus.id_ex_flush, bus.fetch_valid}); end
    n_vec++; if (bus.pc_next !== 32'h0) begin n_bad++; $display("FAIL rst_pcnext: got %h want 0", bus.pc_next); end
    n_vec++; if ({bus.stall_count, bus.flush_count, bus.imem_timeout} !== 65'h0) begin n_bad++; $display("FAIL rst_cnt: stall=%0d flush=%0d to=%b want 0", bus.stall_count, bus.flush_count, bus.imem_timeout); end
    $display("reset: state=%0d pcwe=%b", bus.state_out, bus.pc_write_enable);
  endtask

  task automatic test_boot();
    next_cycle(); RESET = 1'b1; #1;
    n_vec++; if (bus.pc_write_enable !== 1'b0) begin n_bad++; $display("FAIL boot_c1_pcwe: got %b want 0", bus.pc_write_enable); end
    next_cycle(); #1;
    n_vec++; if ({bus.pc_write_enable, bus.pc_next} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL boot_c2_load: pcwe=%b pc_next=%h want 1/0", bus.pc_write_enable, bus.pc_next); end
    n_vec++; if (bus.state_out !== 3'd0) begin n_bad++; $display("FAIL boot_c2_state: got %0d want 0", bus.state_out); end
    for (int i = 1; i <= 3; i++) begin
      next_cycle(); #1;
      n_vec++; if ({bus.fetch_valid, bus.pc_next} !== {1'b1, 32'(4 * i)}) begin n_bad++; $display("FAIL boot_seq[%0d]: fv=%b pc_next=%h want 1/%h", i, bus.fetch_valid, bus.pc_next, 32'(4 * i)); end
      $display("boot fetch %0d: pc_next=%h fv=%b", i, bus.pc_next, bus.fetch_valid);
    end
    n_vec++; if ({bus.stall_count, bus.flush_count} !== 64'h0) begin n_bad++; $display("FAIL boot_cnt: stall=%0d flush=%0d want 0/0", bus.stall_count, bus.flush_count); end
  endtask

  task automatic test_branch();
    next_cycle();
    pc_ovr_en = 1'b1; pc_ovr = 32'h20;
    bus.branch_taken = 1'b1; bus.branch_target = 32'h100; #1;
    n_vec++; if ({bus.pc_write_enable, bus.pc_next} !== {1'b1, 32'h100}) begin n_bad++; $display("FAIL br_target: pcwe=%b pc_next=%h want 1/100", bus.pc_write_enable, bus.pc_next); end
    n_vec++; if ({bus.if_id_flush, bus.id_ex_flush, bus.fetch_valid} !== 3'b110) begin n_bad++; $display("FAIL br_flush: got %b want 110", {bus.if_id_flush, bus.id_ex_flush, bus.fetch_valid}); end
    next_cycle();
    pc_ovr_en = 1'b0;
    bus.branch_target = 32'h500; #1; // branch held high: REDIRECT must ignore it
    n_vec++; if (bus.state_out !== 3'd4) begin n_bad++; $display("FAIL redir_state: got %0d want 4", bus.state_out); end
    n_vec++; if ({bus.pc_write_enable, bus.pc_next, bus.if_id_flush} !== {1'b1, 32'h104, 1'b1}) begin n_bad++; $display("FAIL redir_pc: pcwe=%b pc_next=%h flush=%b want 1/104/1", bus.pc_write_enable, bus.pc_next, bus.if_id_flush); end
    next_cycle();
    bus.branch_taken = 1'b0; #1;
    n_vec++; if ({bus.state_out, bus.pc_next, bus.fetch_valid} !== {3'd1, 32'h108, 1'b1}) begin n_bad++; $display("FAIL br_resume: state=%0d pc_next=%h fv=%b want 1/108/1", bus.state_out, bus.pc_next, bus.fetch_valid); end
    n_vec++; if (bus.flush_count !== 32'd2) begin n_bad++; $display("FAIL br_flushcnt: got %0d want 2", bus.flush_count); end
    $display("branch: resume pc_next=%h flush_count=%0d", bus.pc_next, bus.flush_count);
  endtask

  task automatic test_mul_div();
    for (int i = 1; i <= 5; i++) begin
      next_cycle();
      bus.mul_div_busy = 1'b1;
      bus.branch_taken = (i == 2); bus.load_use_hazard = (i == 2);
      bus.branch_target = 32'h700; #1;
      n_vec++; if ({bus.pc_write_enable, bus.if_id_write_enable, bus.id_ex_flush} !== 3'b000) begin n_bad++; $display("FAIL busy_hold[%0d]: pcwe/ifwe/idexfl=%b want 000", i, {bus.pc_write_enable, bus.if_id_write_enable, bus.id_ex_flush}); end
    end
    next_cycle();
    bus.mul_div_busy = 1'b0; bus.branch_taken = 1'b0; bus.load_use_hazard = 1'b0; #1;
    n_vec++; if ({bus.pc_write_enable, bus.pc_next, bus.fetch_valid} !== {1'b1, 32'h10C, 1'b1}) begin n_bad++; $display("FAIL busy_resume: pcwe=%b pc_next=%h fv=%b want 1/10c/1", bus.pc_write_enable, bus.pc_next, bus.fetch_valid); end
    n_vec++; if (bus.stall_count !== 32'd5) begin n_bad++; $display("FAIL busy_stallcnt: got %0d want 5", bus.stall_count); end
    $display("mul_div: resume pc_next=%h stall_count=%0d", bus.pc_next, bus.stall_count);
  endtask

  task automatic test_load_use();
    next_cycle();
    bus.load_use_hazard = 1'b1; #1;
    n_vec++; if ({bus.pc_write_enable, bus.if_id_write_enable, bus.id_ex_flush} !== 3'b001) begin n_bad++; $display("FAIL lu_hold: pcwe/ifwe/idexfl=%b want 001", {bus.pc_write_enable, bus.if_id_write_enable, bus.id_ex_flush}); end
    next_cycle();
    bus.load_use_hazard = 1'b0; #1;
    n_vec++; if ({bus.pc_write_enable, bus.pc_next, bus.id_ex_flush} !== {1'b1, 32'h110, 1'b0}) begin n_bad++; $display("FAIL lu_resume: pcwe=%b pc_next=%h idexfl=%b want 1/110/0", bus.pc_write_enable, bus.pc_next, bus.id_ex_flush); end
    n_vec++; if (bus.stall_count !== 32'd6) begin n_bad++; $display("FAIL lu_stallcnt: got %0d want 6", bus.stall_count); end
    $display("load_use: resume pc_next=%h", bus.pc_next);
  endtask

  task automatic test_imem_wait();
    logic exp_to;
    pc_ovr_en = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      next_cycle();
      pc_ovr_en = 1'b1; pc_ovr = 32'hFFFF_FFFC;
      bus.imem_ready = 1'b0; #1;
      exp_to = (i >= 17);
      n_vec++; if ({bus.pc_write_enable, bus.if_id_flush, bus.fetch_valid, bus.imem_timeout} !== {3'b010, exp_to}) begin n_bad++; $display("FAIL wait[%0d]: pcwe/flush/fv/to=%b want 010%b", i, {bus.pc_write_enable, bus.if_id_flush, bus.fetch_valid, bus.imem_timeout}, exp_to); end
    end
    next_cycle();
    bus.imem_ready = 1'b1; #1;
    n_vec++; if ({bus.state_out, bus.pc_write_enable, bus.pc_next, bus.fetch_valid} !== {3'd3, 1'b1, 32'h0, 1'b1}) begin n_bad++; $display("FAIL wait_ready: state=%0d pcwe=%b pc_next=%h fv=%b want 3/1/0/1", bus.state_out, bus.pc_write_enable, bus.pc_next, bus.fetch_valid); end
    n_vec++; if ({bus.stall_count, bus.flush_count} !== {32'd26, 32'd22}) begin n_bad++; $display("FAIL wait_cnt: stall=%0d flush=%0d want 26/22", bus.stall_count, bus.flush_count); end
    next_cycle();
    pc_ovr_en = 1'b0; #1;
    n_vec++; if ({bus.imem_timeout, bus.state_out} !== {1'b1, 3'd1}) begin n_bad++; $display("FAIL wait_sticky: to=%b state=%0d want 1/1", bus.imem_timeout, bus.state_out); end
    $display("imem_wait: timeout=%b stall=%0d flush=%0d", bus.imem_timeout, bus.stall_count, bus.flush_count);
  endtask

  task automatic test_reset_mid();
    // Reset in the middle of IMEM_WAIT
    next_cycle(); bus.imem_ready = 1'b0;
    next_cycle(); #1;
    n_vec++; if (bus.state_out !== 3'd3) begin n_bad++; $display("FAIL mid_wait_state: got %0d want 3", bus.state_out); end
    #2 RESET = 1'b0; #1;
    n_vec++; if ({bus.state_out, bus.pc_write_enable, bus.if_id_flush, bus.id_ex_flush, bus.pc_next} !== {3'd0, 3'b011, 32'h0}) begin n_bad++; $display("FAIL mid_wait_rst: state=%0d pcwe=%b pc_next=%h want 0/0/0", bus.state_out, bus.pc_write_enable, bus.pc_next); end
    n_vec++; if ({bus.stall_count, bus.flush_count, bus.imem_timeout} !== 65'h0) begin n_bad++; $display("FAIL mid_wait_cnt: stall=%0d flush=%0d to=%b want 0", bus.stall_count, bus.flush_count, bus.imem_timeout); end
    // Boot again, branch, then reset during REDIRECT
    next_cycle(); RESET = 1'b1; bus.imem_ready = 1'b1;
    next_cycle();
    next_cycle(); bus.branch_taken = 1'b1; bus.branch_target = 32'h40;
    next_cycle(); bus.branch_taken = 1'b0; #1;
    n_vec++; if ({bus.state_out, bus.flush_count} !== {3'd4, 32'd1}) begin n_bad++; $display("FAIL mid_redir_pre: state=%0d flush=%0d want 4/1", bus.state_out, bus.flush_count); end
    #2 RESET = 1'b0; #1;
    n_vec++; if ({bus.state_out, bus.pc_write_enable, bus.fetch_valid, bus.pc_next} !== {3'd0, 2'b00, 32'h0}) begin n_bad++; $display("FAIL mid_redir_rst: state=%0d pcwe=%b fv=%b pc_next=%h want 0/0/0/0", bus.state_out, bus.pc_write_enable, bus.fetch_valid, bus.pc_next); end
    n_vec++; if (bus.flush_count !== 32'd0) begin n_bad++; $display("FAIL mid_redir_cnt: flush=%0d want 0", bus.flush_count); end
    $display("reset_mid: state=%0d", bus.state_out);
    next_cycle(); RESET = 1'b1;
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    RESET = 1'b0;
    pc_ovr_en = 1'b0; pc_ovr = 32'h0;
    bus.branch_taken = 1'b0; bus.branch_target = 32'h0;
    bus.load_use_hazard = 1'b0; bus.mul_div_busy = 1'b0;
    bus.imem_ready = 1'b1;
    test_reset();
    test_boot();
    test_branch();
    test_mul_div();
    test_load_use();
    test_imem_wait();
    test_reset_mid();
    repeat (2) next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
